// File: rtl/ex_stage.sv
module ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            EX_valid,
  output logic            EX_ready,
  input  logic [4:0]      EX_ALU_Ctrl,
  input  logic [XLEN-1:0] EX_rs1_data,
  input  logic [XLEN-1:0] EX_rs2_data,
  input  logic [XLEN-1:0] EX_imm,
  input  logic [XLEN-1:0] EX_pc,
  input  logic            EX_a_sel,
  input  logic            EX_b_sel,
  input  logic            EX_jal,
  input  logic [4:0]      EX_rd,
  input  logic            EX_wb_en,
  input  logic            EX_mem_rd,
  input  logic            EX_mem_wr,
  input  logic [2:0]      EX_funct3,
  input  logic            flush,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            MEM_valid,
  input  logic            MEM_ready,
  output logic [XLEN-1:0] MEM_alu_out,
  output logic [XLEN-1:0] MEM_rs2_data,
  output logic [4:0]      MEM_rd,
  output logic            MEM_wb_en,
  output logic            MEM_mem_rd,
  output logic            MEM_mem_wr,
  output logic [2:0]      MEM_funct3
);

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_SLL  = 5'd2,  ALU_SLT  = 5'd3,
    ALU_SLTU = 5'd4,  ALU_XOR  = 5'd5,  ALU_SRL  = 5'd6,  ALU_SRA  = 5'd7,
    ALU_OR   = 5'd8,  ALU_AND  = 5'd9,  ALU_JALR = 5'd10, ALU_BEQ  = 5'd11,
    ALU_BNE  = 5'd12, ALU_BLT  = 5'd13, ALU_BGE  = 5'd14, ALU_BLTU = 5'd15,
    ALU_BGEU = 5'd16, ALU_IMM  = 5'd17
  } alu_op_e;

  alu_op_e         op;
  logic [XLEN-1:0] op_a, op_b, pc_plus4, result, target;
  logic            taken, is_branch, load;

  logic            mem_valid_q, mem_valid_d;
  logic [XLEN-1:0] mem_alu_out_q, mem_alu_out_d;
  logic [XLEN-1:0] mem_rs2_data_q, mem_rs2_data_d;
  logic [4:0]      mem_rd_q, mem_rd_d;
  logic            mem_wb_en_q, mem_wb_en_d;
  logic            mem_mem_rd_q, mem_mem_rd_d;
  logic            mem_mem_wr_q, mem_mem_wr_d;
  logic [2:0]      mem_funct3_q, mem_funct3_d;

  assign op = alu_op_e'(EX_ALU_Ctrl);

  always_comb begin
    op_a      = EX_a_sel ? EX_pc : EX_rs1_data;
    op_b      = EX_b_sel ? EX_imm : EX_rs2_data;
    pc_plus4  = EX_pc + XLEN'(4);
    result    = '0;
    taken     = 1'b0;
    is_branch = 1'b0;
    target    = EX_pc + EX_imm;
    case (op)
      ALU_ADD:  result = op_a + op_b;
      ALU_SUB:  result = op_a - op_b;
      ALU_SLL:  result = op_a << op_b[4:0];
      ALU_SLT:  result = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU: result = XLEN'(op_a < op_b);
      ALU_XOR:  result = op_a ^ op_b;
      ALU_SRL:  result = op_a >> op_b[4:0];
      ALU_SRA:  result = $unsigned($signed(op_a) >>> op_b[4:0]);
      ALU_OR:   result = op_a | op_b;
      ALU_AND:  result = op_a & op_b;
      ALU_JALR: begin
        result = pc_plus4;
        taken  = 1'b1;
        target = (EX_rs1_data + EX_imm) & ~XLEN'(1);
      end
      ALU_BEQ:  begin is_branch = 1'b1; taken = (EX_rs1_data == EX_rs2_data); end
      ALU_BNE:  begin is_branch = 1'b1; taken = (EX_rs1_data != EX_rs2_data); end
      ALU_BLT:  begin is_branch = 1'b1; taken = ($signed(EX_rs1_data) <  $signed(EX_rs2_data)); end
      ALU_BGE:  begin is_branch = 1'b1; taken = ($signed(EX_rs1_data) >= $signed(EX_rs2_data)); end
      ALU_BLTU: begin is_branch = 1'b1; taken = (EX_rs1_data <  EX_rs2_data); end
      ALU_BGEU: begin is_branch = 1'b1; taken = (EX_rs1_data >= EX_rs2_data); end
      ALU_IMM:  result = EX_imm;
      default:  result = '0;
    endcase
    // JAL overrides whatever code ID supplied, including branch wb suppression
    if (EX_jal) begin
      result    = pc_plus4;
      taken     = 1'b1;
      target    = EX_pc + EX_imm;
      is_branch = 1'b0;
    end
  end

  assign EX_ready    = !mem_valid_q || MEM_ready;
  assign load        = EX_valid && EX_ready && !flush;
  assign redirect    = load && taken;
  assign redirect_pc = target;

  always_comb begin
    mem_alu_out_d  = mem_alu_out_q;
    mem_rs2_data_d = mem_rs2_data_q;
    mem_rd_d       = mem_rd_q;
    mem_wb_en_d    = mem_wb_en_q;
    mem_mem_rd_d   = mem_mem_rd_q;
    mem_mem_wr_d   = mem_mem_wr_q;
    mem_funct3_d   = mem_funct3_q;
    if (load) begin
      mem_alu_out_d  = result;
      mem_rs2_data_d = EX_rs2_data;
      mem_rd_d       = EX_rd;
      mem_wb_en_d    = EX_wb_en && !is_branch;
      mem_mem_rd_d   = EX_mem_rd;
      mem_mem_wr_d   = EX_mem_wr;
      mem_funct3_d   = EX_funct3;
    end
    if (flush)          mem_valid_d = 1'b0;
    else if (load)      mem_valid_d = 1'b1;
    else if (MEM_ready) mem_valid_d = 1'b0;
    else                mem_valid_d = mem_valid_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_valid_q    <= 1'b0;
      mem_alu_out_q  <= '0;
      mem_rs2_data_q <= '0;
      mem_rd_q       <= '0;
      mem_wb_en_q    <= 1'b0;
      mem_mem_rd_q   <= 1'b0;
      mem_mem_wr_q   <= 1'b0;
      mem_funct3_q   <= '0;
    end else begin
      mem_valid_q    <= mem_valid_d;
      mem_alu_out_q  <= mem_alu_out_d;
      mem_rs2_data_q <= mem_rs2_data_d;
      mem_rd_q       <= mem_rd_d;
      mem_wb_en_q    <= mem_wb_en_d;
      mem_mem_rd_q   <= mem_mem_rd_d;
      mem_mem_wr_q   <= mem_mem_wr_d;
      mem_funct3_q   <= mem_funct3_d;
    end
  end

  assign MEM_valid    = mem_valid_q;
  assign MEM_alu_out  = mem_alu_out_q;
  assign MEM_rs2_data = mem_rs2_data_q;
  assign MEM_rd       = mem_rd_q;
  assign MEM_wb_en    = mem_wb_en_q;
  assign MEM_mem_rd   = mem_mem_rd_q;
  assign MEM_mem_wr   = mem_mem_wr_q;
  assign MEM_funct3   = mem_funct3_q;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        EX_valid = 1'b0;
  logic        EX_ready;
  logic [4:0]  EX_ALU_Ctrl = '0;
  logic [31:0] EX_rs1_data = '0, EX_rs2_data = '0, EX_imm = '0, EX_pc = '0;
  logic        EX_a_sel = 1'b0, EX_b_sel = 1'b0, EX_jal = 1'b0;
  logic [4:0]  EX_rd = '0;
  logic        EX_wb_en = 1'b0, EX_mem_rd = 1'b0, EX_mem_wr = 1'b0;
  logic [2:0]  EX_funct3 = '0;
  logic        flush = 1'b0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        MEM_valid;
  logic        MEM_ready = 1'b1;
  logic [31:0] MEM_alu_out, MEM_rs2_data;
  logic [4:0]  MEM_rd;
  logic        MEM_wb_en, MEM_mem_rd, MEM_mem_wr;
  logic [2:0]  MEM_funct3;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .EX_valid(EX_valid), .EX_ready(EX_ready),
    .EX_ALU_Ctrl(EX_ALU_Ctrl), .EX_rs1_data(EX_rs1_data), .EX_rs2_data(EX_rs2_data),
    .EX_imm(EX_imm), .EX_pc(EX_pc), .EX_a_sel(EX_a_sel), .EX_b_sel(EX_b_sel),
    .EX_jal(EX_jal), .EX_rd(EX_rd), .EX_wb_en(EX_wb_en), .EX_mem_rd(EX_mem_rd),
    .EX_mem_wr(EX_mem_wr), .EX_funct3(EX_funct3), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc), .MEM_valid(MEM_valid),
    .MEM_ready(MEM_ready), .MEM_alu_out(MEM_alu_out), .MEM_rs2_data(MEM_rs2_data),
    .MEM_rd(MEM_rd), .MEM_wb_en(MEM_wb_en), .MEM_mem_rd(MEM_mem_rd),
    .MEM_mem_wr(MEM_mem_wr), .MEM_funct3(MEM_funct3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] m_result(input logic [4:0] code, input logic [31:0] rs1, rs2,
                                           imm, pc, input logic asel, bsel, jal);
    logic [31:0] a, b;
    int sa, sb;
    a = asel ? pc : rs1;
    b = bsel ? imm : rs2;
    sa = a; sb = b;
    if (jal) return pc + 4;
    case (code)
      0: return a + b;
      1: return a - b;
      2: return a << b[4:0];
      3: return (sa < sb) ? 1 : 0;
      4: return (a < b) ? 1 : 0;
      5: return a ^ b;
      6: return a >> b[4:0];
      7: return sa >>> b[4:0];
      8: return a | b;
      9: return a & b;
      10: return pc + 4;
      17: return imm;
      default: return 0;
    endcase
  endfunction

  function automatic logic m_taken(input logic [4:0] code, input logic [31:0] rs1, rs2, input logic jal);
    int s1, s2;
    s1 = rs1; s2 = rs2;
    if (jal || code == 10) return 1'b1;
    case (code)
      11: return rs1 == rs2;
      12: return rs1 != rs2;
      13: return s1 < s2;
      14: return s1 >= s2;
      15: return rs1 < rs2;
      16: return rs1 >= rs2;
      default: return 1'b0;
    endcase
  endfunction

  logic        m_valid = 1'b0;
  logic [31:0] m_alu, m_rs2;
  logic [4:0]  m_rd;
  logic        m_wb, m_mrd, m_mwr;
  logic [2:0]  m_f3;

  always @(posedge clk) begin
    logic rdy, ld, br;
    rdy = !m_valid || MEM_ready;
    ld  = EX_valid && rdy && !flush;
    br  = !EX_jal && EX_ALU_Ctrl >= 11 && EX_ALU_Ctrl <= 16;
    if (!rst_n) begin
      m_valid <= 0; m_alu <= 0; m_rs2 <= 0; m_rd <= 0;
      m_wb <= 0; m_mrd <= 0; m_mwr <= 0; m_f3 <= 0;
    end else begin
      if (ld) begin
        m_alu <= m_result(EX_ALU_Ctrl, EX_rs1_data, EX_rs2_data, EX_imm, EX_pc,
                          EX_a_sel, EX_b_sel, EX_jal);
        m_rs2 <= EX_rs2_data; m_rd <= EX_rd; m_wb <= EX_wb_en && !br;
        m_mrd <= EX_mem_rd; m_mwr <= EX_mem_wr; m_f3 <= EX_funct3;
      end
      m_valid <= flush ? 1'b0 : ld ? 1'b1 : MEM_ready ? 1'b0 : m_valid;
    end
  end

  always @(negedge clk) begin
    logic rdy, exp_redir;
    if (chk_en && rst_n) begin
      rdy = !m_valid || MEM_ready;
      exp_redir = EX_valid && rdy && !flush &&
                  m_taken(EX_ALU_Ctrl, EX_rs1_data, EX_rs2_data, EX_jal);
      chk("m_ex_ready", 32'(EX_ready), 32'(rdy));
      chk("m_redirect", 32'(redirect), 32'(exp_redir));
      if (exp_redir)
        chk("m_redirect_pc", redirect_pc,
            (!EX_jal && EX_ALU_Ctrl == 10) ? ((EX_rs1_data + EX_imm) & 32'hFFFF_FFFE)
                                           : (EX_pc + EX_imm));
      chk("m_mem_valid", 32'(MEM_valid), 32'(m_valid));
      if (m_valid) begin
        chk("m_alu_out", MEM_alu_out, m_alu);
        chk("m_rs2", MEM_rs2_data, m_rs2);
        chk("m_rd", 32'(MEM_rd), 32'(m_rd));
        chk("m_ctrl", {29'd0, MEM_wb_en, MEM_mem_rd, MEM_mem_wr}, {29'd0, m_wb, m_mrd, m_mwr});
        chk("m_funct3", 32'(MEM_funct3), 32'(m_f3));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic present(input logic [4:0] code, input logic [31:0] rs1, rs2, imm, pc,
                         input logic asel, bsel, jal, input logic [4:0] rd);
    EX_valid = 1'b1; EX_ALU_Ctrl = code; EX_rs1_data = rs1; EX_rs2_data = rs2;
    EX_imm = imm; EX_pc = pc; EX_a_sel = asel; EX_b_sel = bsel; EX_jal = jal;
    EX_rd = rd; EX_wb_en = 1'b1; EX_mem_rd = rd[0]; EX_mem_wr = rd[1]; EX_funct3 = rd[4:2];
  endtask

  task automatic issue(input logic [4:0] code, input logic [31:0] rs1, rs2, imm, pc,
                       input logic asel, bsel, jal, input logic [4:0] rd,
                       output logic redir, output logic [31:0] rpc);
    present(code, rs1, rs2, imm, pc, asel, bsel, jal, rd);
    #1;
    redir = redirect; rpc = redirect_pc;
    @(posedge clk); #2;
    EX_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic        rd_o;
    logic [31:0] pc_o;

    // reset held two cycles with a live instruction
    present(5'd0, 32'd1, 32'd2, 32'd0, 32'd0, 0, 0, 0, 5'd31);
    @(posedge clk); #2;
    chk_en = 1'b1;
    #1 chk("rst_redirect", 32'(redirect), 32'd0);
    @(posedge clk); #2;
    chk("rst_mem_valid", 32'(MEM_valid), 32'd0);
    chk("rst_alu_out", MEM_alu_out, 32'd0);
    chk("rst_rs2", MEM_rs2_data, 32'd0);
    chk("rst_ctrl", {19'd0, MEM_rd, MEM_wb_en, MEM_mem_rd, MEM_mem_wr, MEM_funct3}, 32'd0);
    rst_n = 1'b1; EX_valid = 1'b0;
    #1 chk("post_rst_ready", 32'(EX_ready), 32'd1);
    @(posedge clk); #2;

    // ALU sweep, back to back
    issue(5'd1, 32'h8000_0000, 32'h4, 0, 0, 0, 0, 0, 5'd1, rd_o, pc_o);
    chk("sub", MEM_alu_out, 32'h7FFF_FFFC);
    issue(5'd7, 32'h8000_0000, 32'h4, 0, 0, 0, 0, 0, 5'd2, rd_o, pc_o);
    chk("sra", MEM_alu_out, 32'hF800_0000);
    issue(5'd6, 32'h8000_0000, 32'h4, 0, 0, 0, 0, 0, 5'd3, rd_o, pc_o);
    chk("srl", MEM_alu_out, 32'h0800_0000);
    issue(5'd3, 32'h8000_0000, 32'h4, 0, 0, 0, 0, 0, 5'd4, rd_o, pc_o);
    chk("slt", MEM_alu_out, 32'h1);
    issue(5'd4, 32'h8000_0000, 32'h4, 0, 0, 0, 0, 0, 5'd5, rd_o, pc_o);
    chk("sltu", MEM_alu_out, 32'h0);
    issue(5'd2, 32'h8000_0000, 32'h4, 0, 0, 0, 0, 0, 5'd6, rd_o, pc_o);
    chk("sll", MEM_alu_out, 32'h0);
    issue(5'd0, 32'h0, 32'h0, 32'h2000, 32'h1000, 1, 1, 0, 5'd7, rd_o, pc_o);
    chk("auipc", MEM_alu_out, 32'h3000);
    issue(5'd17, 32'h5, 32'h6, 32'hABCD_E000, 32'h0, 0, 1, 0, 5'd8, rd_o, pc_o);
    chk("lui", MEM_alu_out, 32'hABCD_E000);

    // branches and jumps
    issue(5'd13, 32'hFFFF_FFFF, 32'h1, 32'h20, 32'h100, 0, 0, 0, 5'd9, rd_o, pc_o);
    chk("blt_redirect", 32'(rd_o), 32'd1);
    chk("blt_target", pc_o, 32'h120);
    chk("blt_wb_en", 32'(MEM_wb_en), 32'd0);
    issue(5'd15, 32'hFFFF_FFFF, 32'h1, 32'h20, 32'h100, 0, 0, 0, 5'd10, rd_o, pc_o);
    chk("bltu_redirect", 32'(rd_o), 32'd0);
    issue(5'd10, 32'h203, 32'h0, 32'h0, 32'h100, 0, 1, 0, 5'd11, rd_o, pc_o);
    chk("jalr_redirect", 32'(rd_o), 32'd1);
    chk("jalr_target", pc_o, 32'h202);
    chk("jalr_link", MEM_alu_out, 32'h104);
    issue(5'd9, 32'h0, 32'h0, 32'h20, 32'h100, 0, 0, 1, 5'd12, rd_o, pc_o);
    chk("jal_target", pc_o, 32'h120);
    chk("jal_link", MEM_alu_out, 32'h104);
    chk("jal_wb_en", 32'(MEM_wb_en), 32'd1);
    issue(5'd20, 32'h7, 32'h9, 32'h0, 32'h0, 0, 0, 0, 5'd13, rd_o, pc_o);
    chk("code20_redirect", 32'(rd_o), 32'd0);
    chk("code20_result", MEM_alu_out, 32'd0);

    // stall: MEM_ready low three cycles with a new instruction waiting
    issue(5'd0, 32'd2, 32'd3, 0, 0, 0, 0, 0, 5'd14, rd_o, pc_o);
    chk("stall_first", MEM_alu_out, 32'd5);
    MEM_ready = 1'b0;
    present(5'd0, 32'd10, 32'd20, 0, 0, 0, 0, 0, 5'd15);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", 32'(EX_ready), 32'd0);
      chk("stall_redirect", 32'(redirect), 32'd0);
      @(posedge clk); #2;
      chk("stall_hold", MEM_alu_out, 32'd5);
    end
    MEM_ready = 1'b1;
    #1 chk("unstall_ready", 32'(EX_ready), 32'd1);
    @(posedge clk); #2;
    EX_valid = 1'b0;
    chk("unstall_result", MEM_alu_out, 32'd30);

    // flush kills a taken branch
    present(5'd11, 32'd7, 32'd7, 32'h20, 32'h100, 0, 0, 0, 5'd16);
    flush = 1'b1;
    #1 chk("flush_redirect", 32'(redirect), 32'd0);
    @(posedge clk); #2;
    flush = 1'b0; EX_valid = 1'b0;
    chk("flush_valid", 32'(MEM_valid), 32'd0);

    // flush while stalled
    issue(5'd0, 32'd1, 32'd1, 0, 0, 0, 0, 0, 5'd17, rd_o, pc_o);
    MEM_ready = 1'b0;
    @(posedge clk); #2;
    chk("stall_valid", 32'(MEM_valid), 32'd1);
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    chk("flush_stall_valid", 32'(MEM_valid), 32'd0);
    MEM_ready = 1'b1;

    // back-to-back ADDI
    for (int i = 1; i <= 4; i++) begin
      issue(5'd0, 32'd100, 32'd0, 32'(i), 0, 0, 1, 0, 5'(i), rd_o, pc_o);
      chk("b2b_valid", 32'(MEM_valid), 32'd1);
      chk("b2b_result", MEM_alu_out, 32'd100 + 32'(i));
    end
    @(posedge clk); #2;
    chk("drain_valid", 32'(MEM_valid), 32'd0);

    // reset while stalled discards the held entry
    issue(5'd0, 32'd8, 32'd8, 0, 0, 0, 0, 0, 5'd18, rd_o, pc_o);
    MEM_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #2;
    chk("rst_stall_valid", 32'(MEM_valid), 32'd0);
    chk("rst_stall_data", MEM_alu_out, 32'd0);
    rst_n = 1'b1; MEM_ready = 1'b1;
    #1 chk("rst_stall_ready", 32'(EX_ready), 32'd1);
    @(posedge clk); #2;
    @(posedge clk); #2;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV32I pipeline: the direct consumer of the 5-bit ALU control code produced by the ALU-control decoder in ID. It selects operands, performs the ALU operation, resolves branches/jumps with a same-cycle redirect, and captures results in the EX/MEM pipeline register. A valid/ready handshake lets MEM stall EX, and a flush input kills the in-flight instruction.

## Interface
- XLEN, 32, datapath width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- EX_valid  in  1  ID/EX holds a live instruction
- EX_ready  out  1  EX can accept this cycle
- EX_ALU_Ctrl  in  5  ALU code: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 JALR, 11 BEQ, 12 BNE, 13 BLT, 14 BGE, 15 BLTU, 16 BGEU, 17 IMM
- EX_rs1_data, EX_rs2_data  in  XLEN  forwarded register operands
- EX_imm  in  XLEN  sign-extended immediate
- EX_pc  in  XLEN  instruction PC
- EX_a_sel  in  1  0: op_a = rs1, 1: op_a = pc (AUIPC)
- EX_b_sel  in  1  0: op_b = rs2, 1: op_b = imm
- EX_jal  in  1  JAL: result pc+4, unconditional redirect to pc+imm
- EX_rd  in  5  destination register
- EX_wb_en, EX_mem_rd, EX_mem_wr  in  1 each  control passed through to MEM
- EX_funct3  in  3  load/store size, passed through
- flush  in  1  kill EX/MEM contents this cycle
- redirect  out  1  taken branch/jump (combinational)
- redirect_pc  out  XLEN  target PC (combinational)
- MEM_valid  out  1  EX/MEM register valid
- MEM_ready  in  1  MEM accepts this cycle
- MEM_alu_out, MEM_rs2_data  out  XLEN  registered result, store data
- MEM_rd, MEM_wb_en, MEM_mem_rd, MEM_mem_wr, MEM_funct3  out  registered controls

## Operation
- Operands: op_a/op_b per selects; all arithmetic modulo 2^32.
- ADD/SUB/XOR/OR/AND standard; SLL/SRL/SRA shift by op_b[4:0], SRA sign-fills; SLT signed, SLTU unsigned, result 0 or 1.
- IMM: result = EX_imm (LUI).
- JALR: result = pc+4; redirect=1, redirect_pc = (rs1+imm) & ~1.
- EX_jal=1 overrides code: result = pc+4; redirect=1, redirect_pc = pc+imm.
- Branches 11–16: compare rs1 vs rs2 (signed for BLT/BGE, unsigned for BLTU/BGEU); redirect = condition, redirect_pc = pc+imm; result = 0, MEM_wb_en forced 0.
- Codes 18–31: result 0, no redirect, controls pass unchanged.
- redirect asserts only when EX_valid && EX_ready && !flush; otherwise 0, redirect_pc don't-care (drive pc+imm).
- Handshake: EX_ready = !MEM_valid || MEM_ready. Load when EX_valid && EX_ready. If MEM_valid && !MEM_ready, all MEM_* hold.
- MEM_valid next: 0 on flush; else 1 on load; else 0 if MEM_ready; else hold.
- flush priority: over load and hold; flush and EX_valid same cycle → instruction dropped, no redirect.

## Timing
- Reset (rst_n=0 at edge): MEM_valid=0, MEM_alu_out=0, MEM_rs2_data=0, MEM_rd=0, all MEM control bits 0, MEM_funct3=0. Reset mid-stall discards held entry. EX_ready=1 the cycle after reset.
- redirect/redirect_pc: same cycle as EX_valid, combinational.
- Result latency: 1 cycle (MEM_* valid the edge after load).
- Throughput: 1/cycle while MEM_ready=1; back-to-back loads allowed while draining (MEM_valid && MEM_ready).
- Stall: MEM_ready=0 holds EX/MEM and deasserts EX_ready; ID must hold inputs; no redirect while stalled.

## Test plan
- Reset: rst_n=0 two cycles with EX_valid=1 → MEM_valid=0, all MEM_* 0, redirect=0; first cycle after release EX_ready=1.
- ALU sweep: rs1=0x8000_0000, rs2=0x0000_0004, b_sel=0 → next cycle SUB 0x7FFF_FFFC, SRA 0xF800_0000, SRL 0x0800_0000, SLT 1, SLTU 0, SLL 0x0000_0000.
- Branch/jump: pc=0x100, imm=0x20; BLT rs1=-1 rs2=1 → redirect=1, redirect_pc=0x120, MEM_wb_en=0; BLTU same operands → redirect=0; JALR rs1=0x203, imm=0 → redirect_pc=0x202, MEM_alu_out=0x104.
- Stall: load ADD (result 5), hold MEM_ready=0 three cycles while presenting new instr → MEM_alu_out stays 5, EX_ready=0, redirect=0; release → new result next edge.
- Flush: EX_valid=1 with taken BEQ and flush=1 → redirect=0, MEM_valid=0 next cycle; flush while MEM_valid held by stall → MEM_valid=0.
- Back-to-back: four consecutive ADDI with MEM_ready=1 → four consecutive MEM_valid cycles, results in order.
